// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with a single-request line-fill port.
// Hits answer combinationally; a miss runs IDLE -> FETCH -> FILL and the retried
// access then hits. Saturating hit/miss counters are kept for performance debug.
module icache_direct #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5,
  localparam int S_TAG   = 32 - S_OFFSET - S_INDEX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_read,
  input  logic [31:0]  instr_mem_address,
  output logic [31:0]  instr_mem_rdata,
  output logic         instr_mem_resp,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int NSETS  = 2 ** S_INDEX;
  localparam int S_WORD = S_OFFSET - 2;

  typedef enum logic [1:0] {IDLE, FETCH, FILL} state_e;

  state_e                     state_q, state_d;
  logic [S_TAG+S_INDEX-1:0]   miss_addr_q, miss_addr_d;
  logic [31:0]                hit_count_q, hit_count_d;
  logic [31:0]                miss_count_q, miss_count_d;

  logic                       valid_q [NSETS];
  logic [S_TAG-1:0]           tag_q   [NSETS];
  logic [255:0]               data_q  [NSETS];

  logic [S_TAG-1:0]           addr_tag;
  logic [S_INDEX-1:0]         addr_idx;
  logic [S_WORD-1:0]          addr_word;
  logic [S_TAG-1:0]           fill_tag;
  logic [S_INDEX-1:0]         fill_idx;
  logic                       hit;
  logic                       miss_take;
  logic                       fill_en;

  assign addr_tag  = instr_mem_address[31 -: S_TAG];
  assign addr_idx  = instr_mem_address[S_OFFSET +: S_INDEX];
  assign addr_word = instr_mem_address[2 +: S_WORD];
  assign fill_idx  = miss_addr_q[S_INDEX-1:0];
  assign fill_tag  = miss_addr_q[S_INDEX +: S_TAG];

  // Hits are only honoured in IDLE so a bubble separates a fill from its retry.
  assign hit       = instr_read && valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag)
                     && (state_q == IDLE);
  assign miss_take = instr_read && !hit && (state_q == IDLE);
  // state_q is forced to IDLE by reset, so a late pmem_resp can never fill.
  assign fill_en   = (state_q == FETCH) && pmem_resp;

  assign instr_mem_resp  = hit;
  assign instr_mem_rdata = data_q[addr_idx][32*addr_word +: 32];
  assign pmem_address    = {miss_addr_q, {S_OFFSET{1'b0}}};
  assign hit_count       = hit_count_q;
  assign miss_count      = miss_count_q;

  // Next-state logic for the miss FSM and the latched miss line address.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    pmem_read   = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_take) begin
          miss_addr_d = {addr_tag, addr_idx};
          state_d     = FETCH;
        end
      end
      FETCH: begin
        pmem_read = 1'b1;
        if (pmem_resp) state_d = FILL;
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Saturating performance counters.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && (hit_count_q != 32'hFFFF_FFFF))        hit_count_d  = hit_count_q + 32'd1;
    if (miss_take && (miss_count_q != 32'hFFFF_FFFF)) miss_count_d = miss_count_q + 32'd1;
  end

  // Control state, miss address and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      miss_addr_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Valid bits: cleared by reset, set when a fill lands in the set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSETS; i++) valid_q[i] <= 1'b0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and line storage; unreset because valid gates every use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= pmem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: a latency-3 line memory model answers fills,
// and each scenario compares outputs against hand-computed expectations.
module tb_icache_direct;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         instr_read = 1'b0;
  logic [31:0]  instr_mem_address = 32'h0;
  logic [31:0]  instr_mem_rdata;
  logic         instr_mem_resp;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  localparam int MEM_LAT = 3;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // memory model bookkeeping (written only by the responder)
  int          fetch_cnt = 0;
  int          fill_total = 0;
  logic [31:0] fill_log [64];
  int          pulse_done_cnt = 0;
  // written only by the stimulus process
  int          pulse_req_cnt = 0;

  icache_direct dut (
    .clk               (clk),
    .rst               (rst),
    .instr_read        (instr_read),
    .instr_mem_address (instr_mem_address),
    .instr_mem_rdata   (instr_mem_rdata),
    .instr_mem_resp    (instr_mem_resp),
    .pmem_read         (pmem_read),
    .pmem_address      (pmem_address),
    .pmem_rdata        (pmem_rdata),
    .pmem_resp         (pmem_resp),
    .hit_count         (hit_count),
    .miss_count        (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] line, input int w);
    if (line == 32'h60 && w == 3) return 32'hDEAD_BEEF;
    return (line ^ 32'hC0DE_0000) + 32'(w) * 32'h0101_0101;
  endfunction

  function automatic logic [255:0] mk_line(input logic [31:0] line);
    logic [255:0] l;
    l = '0;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = mem_word(line, w);
    return l;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: answers a pmem_read on its MEM_LAT-th cycle, plus manual stray pulses.
  always @(posedge clk) begin
    #1;
    if (pulse_req_cnt != pulse_done_cnt) begin
      pmem_resp  = 1'b1;
      pmem_rdata = mk_line(32'h80);
      pulse_done_cnt++;
      fetch_cnt = 0;
    end else if (pmem_read && rst) begin
      fetch_cnt++;
      if (fetch_cnt == MEM_LAT) begin
        pmem_resp  = 1'b1;
        pmem_rdata = mk_line(pmem_address);
        fill_log[fill_total % 64] = pmem_address;
        fill_total++;
        fetch_cnt = 0;
      end else begin
        pmem_resp = 1'b0;
      end
    end else begin
      pmem_resp = 1'b0;
      fetch_cnt = 0;
    end
  end

  // One fetch transaction: hold the address until resp, check latency, address, data.
  task automatic do_fetch(input logic [31:0] addr, input int exp_cyc, input string tag);
    int cyc;
    logic [31:0] line;
    line = addr & ~32'h1F;
    @(posedge clk); #2;
    instr_read = 1'b1;
    instr_mem_address = addr;
    #1;
    cyc = 0;
    while (!instr_mem_resp && cyc < 60) begin
      if (exp_cyc > 0 && cyc >= 1 && cyc <= MEM_LAT + 1)
        check_eq({tag, "_pread"}, 32'(pmem_read), 32'(cyc <= MEM_LAT));
      if (pmem_read) check_eq({tag, "_paddr"}, pmem_address, line);
      @(posedge clk); #3;
      cyc++;
    end
    if (exp_cyc == 0) check_eq({tag, "_nopread"}, 32'(pmem_read), 32'd0);
    check_eq({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
    check_eq({tag, "_rdata"}, instr_mem_rdata, mem_word(line, int'(addr[4:2])));
    if (exp_cyc > 0) exp_misses++;
    exp_hits++;
    $display("[TB] fetch %s addr=%h cycles=%0d rdata=%h", tag, addr, cyc, instr_mem_rdata);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #2;
    instr_read = 1'b0;
    #1;
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_hits"}, hit_count, 32'(exp_hits));
    check_eq({tag, "_misses"}, miss_count, 32'(exp_misses));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int fills0;
    int resp_other;

    // reset state
    repeat (3) @(posedge clk);
    #3;
    check_eq("rst_resp", 32'(instr_mem_resp), 32'd0);
    check_eq("rst_pread", 32'(pmem_read), 32'd0);
    check_eq("rst_paddr", pmem_address, 32'h0);
    check_eq("rst_hits", hit_count, 32'h0);
    check_eq("rst_misses", miss_count, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;

    // 1: cold miss, 5-cycle response with word3 = DEADBEEF
    do_fetch(32'h0000_006C, 5, "cold");
    check_eq("cold_word3", instr_mem_rdata, 32'hDEAD_BEEF);
    idle_cycle();
    check_counters("t1");

    // 2: hit streak over the whole line on consecutive cycles
    for (int w = 0; w < 8; w++) do_fetch(32'h60 + 32'(4*w), 0, "streak");
    idle_cycle();
    check_counters("t2");

    // 3: conflict in set 2 evicts and refetches 0x40
    do_fetch(32'h0000_0040, 5, "conf_a");
    do_fetch(32'h0000_0140, 5, "conf_b");
    do_fetch(32'h0000_0040, 5, "conf_a2");
    idle_cycle();
    check_counters("t3");

    // 4: reset in the 2nd FETCH cycle, then a stray pmem_resp
    @(posedge clk); #2;
    instr_read = 1'b1;
    instr_mem_address = 32'h80;
    @(posedge clk); #3;
    check_eq("rmid_fetch1", 32'(pmem_read), 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_eq("rmid_pread", 32'(pmem_read), 32'd0);
    check_eq("rmid_paddr", pmem_address, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    instr_read = 1'b0;
    pulse_req_cnt++;
    exp_hits = 0;
    exp_misses = 0;
    repeat (2) @(posedge clk);
    #3;
    check_eq("rmid_pread_after", 32'(pmem_read), 32'd0);
    check_counters("t4a");
    do_fetch(32'h0000_0080, 5, "rmid_refetch");
    idle_cycle();
    check_counters("t4b");

    // 5: address changes while the 0x100 fill is in flight
    @(posedge clk); #2;
    fills0 = fill_total;
    resp_other = 0;
    instr_read = 1'b1;
    instr_mem_address = 32'h100;
    #1;
    cyc = 0;
    while (cyc < 60) begin
      if (instr_mem_resp) begin
        if (instr_mem_address == 32'h200) break;
        resp_other++;
      end
      @(posedge clk); #2;
      if (cyc == 0) instr_mem_address = 32'h200;
      #1;
      cyc++;
    end
    check_eq("chg_lat", 32'(cyc), 32'd10);
    check_eq("chg_fills", 32'(fill_total - fills0), 32'd2);
    check_eq("chg_fill0", fill_log[fills0 % 64], 32'h100);
    check_eq("chg_fill1", fill_log[(fills0 + 1) % 64], 32'h200);
    check_eq("chg_resp_other", 32'(resp_other), 32'd0);
    check_eq("chg_rdata", instr_mem_rdata, mem_word(32'h200, 0));
    $display("[TB] fetch chg addr=00000200 cycles=%0d rdata=%h", cyc, instr_mem_rdata);
    exp_misses += 2;
    exp_hits++;
    idle_cycle();
    check_counters("t5");

    // 6: hit counter saturation
    force dut.hit_count_q = 32'hFFFF_FFFE;
    @(posedge clk); #2;
    release dut.hit_count_q;
    #1;
    check_eq("sat_start", hit_count, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      instr_read = 1'b1;
      instr_mem_address = 32'h200;
      #1;
      check_eq("sat_resp", 32'(instr_mem_resp), 32'd1);
      if (i == 2) check_eq("sat_mid", hit_count, 32'hFFFF_FFFF);
    end
    idle_cycle();
    check_eq("sat_end", hit_count, 32'hFFFF_FFFF);
    $display("[TB] saturation hit_count=%h", hit_count);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
